// File: rtl/fma_pkg.sv
// Shared width arithmetic and lane indexing for the dot-product engine.
package fma_pkg;

  // Per-beat sum width: full product width plus log2(LANES) carry bits.
  function automatic int sum_width(input int lanes, input int dw);
    return 2 * dw + $clog2(lanes);
  endfunction

  // Accumulator width: per-beat sum plus headroom for MAX_BEATS beats.
  function automatic int acc_width(input int lanes, input int dw, input int max_beats);
    return sum_width(lanes, dw) + $clog2(max_beats);
  endfunction

  // Low bit index of a lane inside a packed lane bus.
  function automatic int lane_lsb(input int lane, input int width);
    return lane * width;
  endfunction

endpackage

// File: rtl/fma_adder_tree.sv
// Combinational sum of LANES products, extended to SW bits by operand mode.
module fma_adder_tree
  import fma_pkg::*;
#(
  parameter int LANES = 8,
  parameter int DW = 8,
  localparam int PW = 2 * DW,
  localparam int SW = sum_width(LANES, DW)
) (
  input  logic                  is_signed,
  input  logic [LANES*PW-1:0]   products,
  output logic [SW-1:0]         sum
);

  logic [PW-1:0] lane_p;
  logic [SW-1:0] lane_ext;

  // Extend each product to SW bits and reduce; the chain is rebalanced by synthesis.
  always_comb begin
    sum      = '0;
    lane_p   = '0;
    lane_ext = '0;
    for (int i = 0; i < LANES; i++) begin
      lane_p   = products[lane_lsb(i, PW) +: PW];
      lane_ext = {{(SW - PW){is_signed & lane_p[PW-1]}}, lane_p};
      sum      = sum + lane_ext;
    end
  end

endmodule

// File: rtl/fma_dot_engine.sv
// Three-stage pipelined dot-product/accumulate engine with valid/ready on both sides.
//
// Handshake: a beat transfers on a rising edge where in_valid & in_ready; a result
// transfers where out_valid & out_ready. in_ready drops only while a result is
// stalled (out_valid & ~out_ready), and then every stage holds its contents.
module fma_dot_engine
  import fma_pkg::*;
#(
  parameter int LANES = 8,
  parameter int DW = 8,
  parameter int MAX_BEATS = 16,
  localparam int SW = sum_width(LANES, DW),
  localparam int AW = acc_width(LANES, DW, MAX_BEATS)
) (
  input  logic                clk_clk,
  input  logic                reset_reset_n,
  input  logic                clr,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic                in_last,
  input  logic                in_signed,
  input  logic [LANES*DW-1:0] a_bus,
  input  logic [LANES*DW-1:0] b_bus,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [AW-1:0]       out_result,
  output logic                out_ovf,
  output logic                busy
);

  localparam int PW = 2 * DW;
  localparam int CW = $clog2(MAX_BEATS) + 1;

  logic                stall;
  logic                accept;
  logic                in_first;
  logic                mode_q;
  logic                beat_signed;
  logic [LANES*PW-1:0] prod_d;

  logic                s1_valid, s1_last, s1_signed;
  logic [LANES*PW-1:0] s1_prod;
  logic [SW-1:0]       tree_sum;
  logic                s2_valid, s2_last, s2_signed;
  logic [SW-1:0]       s2_sum;

  logic [AW-1:0]       acc;
  logic [CW-1:0]       beat_cnt;
  logic                ovf;
  logic [AW-1:0]       sum_ext;
  logic [AW-1:0]       acc_next;
  logic                ovf_next;

  assign stall    = out_valid & ~out_ready;
  assign in_ready = ~stall;
  assign accept   = in_valid & in_ready;

  // Mode comes from the first beat of a vector; later beats reuse the latched value.
  assign beat_signed = in_first ? in_signed : mode_q;

  // Track vector boundaries on the input side so the mode can be latched.
  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      in_first <= 1'b1;
      mode_q   <= 1'b0;
    end else if (clr) begin
      in_first <= 1'b1;
      mode_q   <= 1'b0;
    end else if (accept) begin
      in_first <= in_last;
      if (in_first) mode_q <= in_signed;
    end
  end

  // Per-lane multipliers: operands extended to PW bits, the low PW product bits are exact.
  for (genvar i = 0; i < LANES; i++) begin : g_lane
    logic [DW-1:0] a_lane, b_lane;
    logic [PW-1:0] a_ext, b_ext;
    assign a_lane = a_bus[lane_lsb(i, DW) +: DW];
    assign b_lane = b_bus[lane_lsb(i, DW) +: DW];
    assign a_ext  = {{DW{beat_signed & a_lane[DW-1]}}, a_lane};
    assign b_ext  = {{DW{beat_signed & b_lane[DW-1]}}, b_lane};
    assign prod_d[lane_lsb(i, PW) +: PW] = a_ext * b_ext;
  end

  fma_adder_tree #(
    .LANES (LANES),
    .DW    (DW)
  ) u_tree (
    .is_signed (s1_signed),
    .products  (s1_prod),
    .sum       (tree_sum)
  );

  // S1 (products) and S2 (beat sum) registers; clr drops both, stall holds both.
  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      s1_valid  <= 1'b0;
      s1_last   <= 1'b0;
      s1_signed <= 1'b0;
      s1_prod   <= '0;
      s2_valid  <= 1'b0;
      s2_last   <= 1'b0;
      s2_signed <= 1'b0;
      s2_sum    <= '0;
    end else if (clr) begin
      s1_valid <= 1'b0;
      s2_valid <= 1'b0;
    end else if (!stall) begin
      s1_valid <= accept;
      if (accept) begin
        s1_prod   <= prod_d;
        s1_last   <= in_last;
        s1_signed <= beat_signed;
      end
      s2_valid <= s1_valid;
      if (s1_valid) begin
        s2_sum    <= tree_sum;
        s2_last   <= s1_last;
        s2_signed <= s1_signed;
      end
    end
  end

  assign sum_ext  = {{(AW - SW){s2_signed & s2_sum[SW-1]}}, s2_sum};
  assign acc_next = (beat_cnt == '0) ? sum_ext : acc + sum_ext;
  assign ovf_next = ovf | (beat_cnt >= CW'(MAX_BEATS));

  // S3: accumulate beats, publish on the last one; a consumed result is replaced in place.
  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      acc        <= '0;
      beat_cnt   <= '0;
      ovf        <= 1'b0;
      out_valid  <= 1'b0;
      out_result <= '0;
      out_ovf    <= 1'b0;
    end else if (clr) begin
      acc        <= '0;
      beat_cnt   <= '0;
      ovf        <= 1'b0;
      out_valid  <= 1'b0;
      out_result <= '0;
      out_ovf    <= 1'b0;
    end else if (!stall) begin
      if (s2_valid && s2_last) begin
        out_result <= acc_next;
        out_ovf    <= ovf_next;
        out_valid  <= 1'b1;
        acc        <= '0;
        beat_cnt   <= '0;
        ovf        <= 1'b0;
      end else begin
        out_valid <= 1'b0;
        if (s2_valid) begin
          acc      <= acc_next;
          ovf      <= ovf_next;
          beat_cnt <= (beat_cnt == CW'(MAX_BEATS)) ? beat_cnt : beat_cnt + 1'b1;
        end
      end
    end
  end

  assign busy = s1_valid | s2_valid | (beat_cnt != '0) | out_valid;

endmodule
